// File: rtl/seq_divider_ctrl_if.sv
// seq_divider_ctrl_if: operand/result bundle between a divide requester and seq_divider_ctrl.
// Signals: start, dividend, divisor (requester -> divider);
//          busy, done, quotient, remainder, div_by_zero (divider -> requester).
// master = requester side, slave = divider side.
interface seq_divider_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider_ctrl.sv
// seq_divider_ctrl: unsigned restoring divider, one trial subtraction (borrow-out decides) per clock.
// Latency: WIDTH edges from accepted start to done; divide-by-zero (and, with
//          SEQ_DIV_EARLY_EXIT_EN defined, dividend<=divisor) goes straight to DONE.
// Backpressure: none; start is only sampled in IDLE, requests while busy are dropped.
// Ports: clk, rst_n (synchronous, active-low); bus (seq_divider_ctrl_if.slave) carries
//        start/dividend/divisor in and busy/done/quotient/remainder/div_by_zero out.
// Optional feature macro: SEQ_DIV_EARLY_EXIT_EN.
module seq_divider_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  seq_divider_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH:0]   r_rem;     // partial remainder
  logic [WIDTH-1:0] q_reg;     // dividend shifting out / quotient shifting in
  logic [WIDTH-1:0] d_reg;     // captured divisor
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             dz_q;

  // Subtractor operands: A = shifted partial remainder, B = divisor, b_in = 0.
  logic [WIDTH:0]   sub_a;
  logic [WIDTH:0]   sub_b;
  logic             sub_bin;
  logic [WIDTH:0]   sub_diff;
  logic             sub_bout;
  logic [WIDTH:0]   r_next;
  logic [WIDTH-1:0] q_next;

  // R < D always holds, so the partial remainder MSB never reaches the shift.
  logic             r_msb_unused;
  assign r_msb_unused = r_rem[WIDTH];

  assign sub_a   = {r_rem[WIDTH-1:0], q_reg[WIDTH-1]};
  assign sub_b   = {1'b0, d_reg};
  assign sub_bin = 1'b0;
  assign {sub_bout, sub_diff} = {1'b0, sub_a} - {1'b0, sub_b} - {{(WIDTH + 1){1'b0}}, sub_bin};

  // Borrow-out set means the trial went negative: restore and shift in a 0.
  assign r_next = sub_bout ? sub_a : sub_diff;
  assign q_next = {q_reg[WIDTH-2:0], ~sub_bout};

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.divisor == '0) begin
            state_nxt = ST_DONE;
          end else begin
`ifdef SEQ_DIV_EARLY_EXIT_EN
            if (bus.dividend <= bus.divisor) begin
              state_nxt = ST_DONE;
            end else begin
              state_nxt = ST_CALC;
            end
`else
            state_nxt = ST_CALC;
`endif
          end
        end
      end
      ST_CALC: begin
        if (cnt == CW'(1)) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (state)
      ST_CALC: bus.busy = 1'b1;
      ST_DONE: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dz_q;

  // Datapath and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rem       <= '0;
      q_reg       <= '0;
      d_reg       <= '0;
      cnt         <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dz_q        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            if (bus.divisor == '0) begin
              quotient_q  <= '1;
              remainder_q <= bus.dividend;
              dz_q        <= 1'b1;
            end else begin
`ifdef SEQ_DIV_EARLY_EXIT_EN
              if (bus.dividend < bus.divisor) begin
                quotient_q  <= '0;
                remainder_q <= bus.dividend;
                dz_q        <= 1'b0;
              end else if (bus.dividend == bus.divisor) begin
                quotient_q  <= WIDTH'(1);
                remainder_q <= '0;
                dz_q        <= 1'b0;
              end else begin
                r_rem <= '0;
                q_reg <= bus.dividend;
                d_reg <= bus.divisor;
                cnt   <= CW'(WIDTH);
              end
`else
              r_rem <= '0;
              q_reg <= bus.dividend;
              d_reg <= bus.divisor;
              cnt   <= CW'(WIDTH);
`endif
            end
          end
        end
        ST_CALC: begin
          r_rem <= r_next;
          q_reg <= q_next;
          cnt   <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            quotient_q  <= q_next;
            remainder_q <= r_next[WIDTH-1:0];
            dz_q        <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_divider_ctrl.sv
// tb_seq_divider_ctrl: scoreboard bench for seq_divider_ctrl (WIDTH=4).
// Driver issues directed and random divisions and queues the arithmetic result;
// a monitor pops and compares on every done pulse, including start-to-done latency.
module tb_seq_divider_ctrl;
  localparam int W = 4;
`ifdef SEQ_DIV_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seq_divider_ctrl_if #(.WIDTH(W)) bus ();

  seq_divider_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           lat;
    int           t0;
  } exp_t;

  exp_t sb[$];
  exp_t last_exp;
  bit   have_last = 1'b0;
  bit   prev_done = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer division; zero divisor gives all-ones quotient.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int t0);
    exp_t e;
    int ai, bi;
    ai = int'(a);
    bi = int'(b);
    e.t0 = t0;
    if (bi == 0) begin
      e.q   = W'((1 << W) - 1);
      e.r   = a;
      e.dz  = 1'b1;
      e.lat = 0;
    end else begin
      e.q   = W'(ai / bi);
      e.r   = W'(ai % bi);
      e.dz  = 1'b0;
      e.lat = (EARLY && ai <= bi) ? 0 : W;
    end
    return e;
  endfunction

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && bus.done === 1'b1) begin
        check("done_single_cycle", 32'(prev_done), 32'd0);
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_done: got done with no pending request expected none (t=%0t)", $time);
        end else begin
          e = sb.pop_front();
          check("quotient", 32'(bus.quotient), 32'(e.q));
          check("remainder", 32'(bus.remainder), 32'(e.r));
          check("div_by_zero", 32'(bus.div_by_zero), 32'(e.dz));
          check("latency", 32'(cyc - e.t0), 32'(e.lat));
        end
      end
      prev_done = (rst_n === 1'b1) && (bus.done === 1'b1);
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.busy !== 1'b0 && n < 100);
    if (bus.busy !== 1'b0) begin
      vectors++;
      miscompares++;
      $display("FAIL idle_timeout: got busy=%0b expected 0 within 100 cycles", bus.busy);
    end
  endtask

  task automatic check_hold();
    if (have_last) begin
      check("hold_quotient", 32'(bus.quotient), 32'(last_exp.q));
      check("hold_remainder", 32'(bus.remainder), 32'(last_exp.r));
      check("hold_div_by_zero", 32'(bus.div_by_zero), 32'(last_exp.dz));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
    check({tag, "_quotient"}, 32'(bus.quotient), 32'd0);
    check({tag, "_remainder"}, 32'(bus.remainder), 32'd0);
    check({tag, "_div_by_zero"}, 32'(bus.div_by_zero), 32'd0);
  endtask

  // Leaves the bench at the negedge of the first cycle after the start edge,
  // with operands scrambled to show captured copies are used.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    wait_idle();
    check_hold();
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    e = model(a, b, cyc + 1);
    sb.push_back(e);
    last_exp  = e;
    have_last = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start    = 1'b0;
    bus.dividend = W'($urandom);
    bus.divisor  = W'($urandom);
    check("busy_after_start", 32'(bus.busy), 32'd1);
  endtask

  initial begin
    int n;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    issue(4'd13, 4'd3);
    issue(4'd15, 4'd1);
    issue(4'd15, 4'd15);
    issue(4'd7, 4'd0);
    issue(4'd9, 4'd2);
    issue(4'd2, 4'd9);

    // Start pulse during CALC must be dropped.
    issue(4'd14, 4'd4);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 4'd1;
    bus.divisor  = 4'd1;
    @(negedge clk);
    bus.start    = 1'b0;

    // Reset in the middle of a division: no done, everything cleared.
    wait_idle();
    check_hold();
    bus.start    = 1'b1;
    bus.dividend = 4'd11;
    bus.divisor  = 4'd2;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("abort");
    have_last = 1'b0;
    rst_n = 1'b1;
    issue(4'd11, 4'd2);

    repeat (300) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      issue(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)));
    end

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    wait_idle();
    repeat (2) @(negedge clk);
    check_hold();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
